// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the raster timing generator.
// Defaults describe 640x480@60 on an 800x525 total raster.
package vga_timing_pkg;

    localparam int unsigned CountW = 14;
    localparam int unsigned AddrW  = 24;

    localparam int unsigned DefHSize = 640;
    localparam int unsigned DefHFp   = 16;
    localparam int unsigned DefHSw   = 96;
    localparam int unsigned DefHBp   = 48;
    localparam int unsigned DefVSize = 480;
    localparam int unsigned DefVFp   = 10;
    localparam int unsigned DefVSw   = 2;
    localparam int unsigned DefVBp   = 33;

    typedef enum logic [1:0] {
        RegActive,
        RegFp,
        RegSync,
        RegBp
    } axis_region_e;

    // Total period of one axis: active + front porch + sync + back porch.
    function automatic int unsigned axis_total(int unsigned size, int unsigned fp,
                                               int unsigned sw, int unsigned bp);
        return size + fp + sw + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus region decode.
// count/active/sync describe the position entered at the next edge so the top can register them.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned SIZE = DefHSize,
    parameter int unsigned FP   = DefHFp,
    parameter int unsigned SW   = DefHSw,
    parameter int unsigned BP   = DefHBp
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              step,
    output logic [CountW-1:0] count,
    output logic              active,
    output logic              sync,
    output logic              wrap
);

    localparam int unsigned Total = axis_total(SIZE, FP, SW, BP);

    localparam logic [CountW-1:0] Last    = CountW'(Total - 1);
    localparam logic [CountW-1:0] SizeEnd = CountW'(SIZE);
    localparam logic [CountW-1:0] FpEnd   = CountW'(SIZE + FP);
    localparam logic [CountW-1:0] SyncEnd = CountW'(SIZE + FP + SW);

    logic [CountW-1:0] count_q, count_d;
    axis_region_e      region;

    // Parks on the last position so the first step lands on zero.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q <= Last;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        wrap    = step && (count_q == Last);
        count_d = count_q;
        if (step) begin
            count_d = wrap ? '0 : count_q + CountW'(1);
        end
    end

    always_comb begin
        if (count_d < SizeEnd) begin
            region = RegActive;
        end else if (count_d < FpEnd) begin
            region = RegFp;
        end else if (count_d < SyncEnd) begin
            region = RegSync;
        end else begin
            region = RegBp;
        end
    end

    assign count  = count_d;
    assign active = (region == RegActive);
    assign sync   = (region == RegSync);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: syncs, DE, coordinates, start pulses and framebuffer read address.
// All outputs are registered from the same next-position decode, so they never skew.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned HSIZE  = DefHSize,
    parameter int unsigned HFP    = DefHFp,
    parameter int unsigned HSW    = DefHSw,
    parameter int unsigned HBP    = DefHBp,
    parameter int unsigned VSIZE  = DefVSize,
    parameter int unsigned VFP    = DefVFp,
    parameter int unsigned VSW    = DefVSw,
    parameter int unsigned VBP    = DefVBp,
    parameter logic        HS_POL = 1'b0,
    parameter logic        VS_POL = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              EN,
    input  logic              Reverse_SW,
    output logic              Hsync,
    output logic              Vsync,
    output logic              DE,
    output logic [CountW-1:0] hpos,
    output logic [CountW-1:0] vpos,
    output logic              line_start,
    output logic              frame_start,
    output logic [AddrW-1:0]  rd_addr
);

    localparam logic [AddrW-1:0] LineStep = AddrW'(HSIZE);
    localparam logic [AddrW-1:0] RevBase  = AddrW'((VSIZE - 1) * HSIZE);

    logic [CountW-1:0] h_count, v_count;
    logic              h_active, h_sync, h_wrap;
    logic              v_active, v_sync, v_wrap;
    logic              v_step;
    logic              de_d;

    logic              rev_q;
    logic [AddrW-1:0]  line_base_q, line_base_d;

    logic              hsync_q, vsync_q, de_q, line_start_q, frame_start_q;
    logic [CountW-1:0] hpos_q, vpos_q;
    logic [AddrW-1:0]  rd_addr_q;

    assign v_step = EN && h_wrap;

    vga_axis_counter #(
        .SIZE (HSIZE),
        .FP   (HFP),
        .SW   (HSW),
        .BP   (HBP)
    ) u_h_counter (
        .CLK    (CLK),
        .RESET  (RESET),
        .step   (EN),
        .count  (h_count),
        .active (h_active),
        .sync   (h_sync),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(
        .SIZE (VSIZE),
        .FP   (VFP),
        .SW   (VSW),
        .BP   (VBP)
    ) u_v_counter (
        .CLK    (CLK),
        .RESET  (RESET),
        .step   (v_step),
        .count  (v_count),
        .active (v_active),
        .sync   (v_sync),
        .wrap   (v_wrap)
    );

    assign de_d = h_active && v_active;

    // Line base walks by HSIZE per active line; direction is fixed for the whole frame.
    always_comb begin
        line_base_d = line_base_q;
        if (v_wrap) begin
            line_base_d = Reverse_SW ? RevBase : '0;
        end else if (v_step && v_active) begin
            line_base_d = rev_q ? line_base_q - LineStep : line_base_q + LineStep;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rev_q       <= 1'b0;
            line_base_q <= '0;
        end else begin
            line_base_q <= line_base_d;
            if (v_wrap) begin
                rev_q <= Reverse_SW;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hpos_q        <= '0;
            vpos_q        <= '0;
            rd_addr_q     <= '0;
        end else if (EN) begin
            hsync_q       <= h_sync ? HS_POL : ~HS_POL;
            vsync_q       <= v_sync ? VS_POL : ~VS_POL;
            de_q          <= de_d;
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            if (de_d) begin
                hpos_q    <= h_count;
                vpos_q    <= v_count;
                rd_addr_q <= line_base_d + AddrW'(h_count);
            end
        end
    end

    assign Hsync       = hsync_q;
    assign Vsync       = vsync_q;
    assign DE          = de_q;
    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign rd_addr     = rd_addr_q;

endmodule
